// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a show-ahead byte FIFO.
// One byte is popped per frame. tx, tx_busy and tx_done are registered.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          bit_end;

    assign bit_end = (baud_cnt == LAST);

    // The pop must be combinational. The FIFO head is then captured in the
    // same IDLE cycle that acknowledges it, so the next frame starts one
    // cycle after the previous stop bit.
    assign fifo_rd_en = (state == IDLE) && !fifo_empty && !reset;

    // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (fifo_rd_en) begin
                        shift_reg <= fifo_rdata;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Registered pulse: raise it one cycle early so that it
                    // lines up with the last stop-bit cycle.
                    tx_done <= (baud_cnt == PRE_LAST);
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with three instances (4, 2 and 7 clocks per bit).
// Stimulus queues the expected bytes, and per-instance monitors check each frame cycle by cycle.
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] reset;
    logic [2:0] empty;
    logic [7:0] rdata [3];
    wire  [2:0] rd_en;
    wire  [2:0] tx;
    wire  [2:0] busy;
    wire  [2:0] done;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int C = (g == 0) ? 4 : (g == 1) ? 2 : 7;

        fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
            .clk        (clk),
            .reset      (reset[g]),
            .fifo_rdata (rdata[g]),
            .fifo_empty (empty[g]),
            .fifo_rd_en (rd_en[g]),
            .tx         (tx[g]),
            .tx_busy    (busy[g]),
            .tx_done    (done[g])
        );

        byte unsigned exp_q[$];
        int pop_cyc[$];
        int rd_ptr     = 0;
        int frames     = 0;
        int aborts     = 0;
        int last_pop   = -1000;
        int last_done  = -1000;
        int reset_err  = 0;
        int idle_err   = 0;
        int bad_pop    = 0;
        int unexpected = 0;

        initial begin : mon
            bit           in_frame;
            bit           prev_rst;
            int           k;
            byte unsigned bt;
            logic [79:0]  gt, gb, gd, et, eb, ed;
            in_frame = 1'b0;
            prev_rst = 1'b0;
            k        = 0;
            forever begin
                @(negedge clk);
                if (reset[g]) begin
                    if (rd_en[g] !== 1'b0) reset_err++;
                    if (prev_rst && (tx[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0))
                        reset_err++;
                    if (in_frame) begin
                        in_frame = 1'b0;
                        aborts++;
                        rd_ptr++;
                    end
                    prev_rst = 1'b1;
                end else begin
                    prev_rst = 1'b0;
                    if (rd_en[g] === 1'b1) begin
                        if (in_frame || empty[g]) bad_pop++;
                        pop_cyc.push_back(cyc);
                        last_pop = cyc;
                    end
                    if (!in_frame && tx[g] === 1'b0) begin
                        in_frame = 1'b1;
                        k  = 0;
                        gt = '0; gb = '0; gd = '0;
                        check($sformatf("u%0d_start_latency", g), cyc - last_pop, 1);
                    end
                    if (in_frame) begin
                        gt[k] = tx[g];
                        gb[k] = busy[g];
                        gd[k] = done[g];
                        if (done[g] === 1'b1) last_done = cyc;
                        k++;
                        if (k == 10 * C) begin
                            in_frame = 1'b0;
                            frames++;
                            if (rd_ptr >= exp_q.size()) begin
                                unexpected++;
                            end else begin
                                bt = exp_q[rd_ptr];
                                rd_ptr++;
                                et = '0; eb = '0; ed = '0;
                                for (int i = 0; i < 10 * C; i++) begin
                                    int b;
                                    b = i / C;
                                    et[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bt[b-1];
                                    eb[i] = 1'b1;
                                end
                                ed[10*C-1] = 1'b1;
                                check($sformatf("u%0d_frame_tx_%02h", g, bt), gt, et);
                                check($sformatf("u%0d_frame_busy_%02h", g, bt), gb, eb);
                                check($sformatf("u%0d_frame_done_%02h", g, bt), gd, ed);
                            end
                        end
                    end else if (busy[g] !== 1'b0 || done[g] !== 1'b0 || tx[g] !== 1'b1) begin
                        idle_err++;
                    end
                end
            end
        end
    end

    function automatic int n_pops(input int g);
        case (g)
            0:       return u[0].pop_cyc.size();
            1:       return u[1].pop_cyc.size();
            default: return u[2].pop_cyc.size();
        endcase
    endfunction

    function automatic int pop_at(input int g, input int i);
        case (g)
            0:       return u[0].pop_cyc[i];
            1:       return u[1].pop_cyc[i];
            default: return u[2].pop_cyc[i];
        endcase
    endfunction

    function automatic int n_frames(input int g);
        case (g)
            0:       return u[0].frames;
            1:       return u[1].frames;
            default: return u[2].frames;
        endcase
    endfunction

    task automatic present(input int g, input logic [7:0] b);
        rdata[g] = b;
        empty[g] = 1'b0;
        case (g)
            0:       u[0].exp_q.push_back(b);
            1:       u[1].exp_q.push_back(b);
            default: u[2].exp_q.push_back(b);
        endcase
    endtask

    // Returns at posedge+1 of the cycle after the pop; the FIFO has advanced by then.
    task automatic wait_pop(input int g);
        int n0;
        int t;
        n0 = n_pops(g);
        t  = 0;
        while (n_pops(g) == n0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check($sformatf("u%0d_pop_seen", g), n_pops(g) - n0, 1);
    endtask

    task automatic wait_frames(input int g, input int n);
        int t;
        t = 0;
        while (n_frames(g) < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check($sformatf("u%0d_frames_reached", g), n_frames(g), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = '1;
        empty    = '1;
        rdata[0] = '0;
        rdata[1] = '0;
        rdata[2] = '0;

        // Reset for 20 cycles, then remain idle with an empty FIFO.
        repeat (20) @(posedge clk);
        #1 reset = '0;
        repeat (20) @(posedge clk);
        #1;
        check("t1_reset_state", u[0].reset_err, 0);
        check("t1_no_pop", n_pops(0), 0);
        check("t1_tx_idle", tx[0], 1'b1);
        check("t1_busy_idle", busy[0], 1'b0);

        // Single byte.
        present(0, 8'hA5);
        wait_pop(0);
        empty[0] = 1'b1;
        wait_frames(0, 1);
        check("t2_one_pop", n_pops(0), 1);

        // Back-to-back frames.
        present(0, 8'h00);
        wait_pop(0);
        present(0, 8'hFF);
        wait_pop(0);
        empty[0] = 1'b1;
        wait_frames(0, 3);
        check("t3_pops", n_pops(0), 3);
        check("t3_pop_spacing", pop_at(0, 2) - pop_at(0, 1), 41);

        // A byte that becomes available mid-frame waits for the first IDLE cycle.
        present(0, 8'h96);
        wait_pop(0);
        empty[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        present(0, 8'h69);
        wait_pop(0);
        empty[0] = 1'b1;
        check("t4_pop_after_done", pop_at(0, 4) - u[0].last_done, 1);
        wait_frames(0, 5);

        // Reset during data bit 3 of 8'h3C, with a non-empty FIFO while reset is held.
        present(0, 8'h3C);
        wait_pop(0);
        empty[0] = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        check("t5_busy_bit3", busy[0], 1'b1);
        check("t5_tx_bit3", tx[0], 1'b1);
        reset[0] = 1'b1;
        rdata[0] = 8'hE7;
        empty[0] = 1'b0;
        check("t5_no_pop_in_reset", rd_en[0], 1'b0);
        @(posedge clk);
        #1;
        check("t5_tx_after_reset", tx[0], 1'b1);
        check("t5_busy_after_reset", busy[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        empty[0] = 1'b1;
        reset[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("t5_no_repop", n_pops(0), 6);
        check("t5_frames", u[0].frames, 5);
        check("t5_aborts", u[0].aborts, 1);
        check("t5_tx_idle", tx[0], 1'b1);

        // Other bit widths.
        for (int g = 1; g < 3; g++) begin
            present(g, 8'h5A);
            wait_pop(g);
            empty[g] = 1'b1;
            wait_frames(g, 1);
            check($sformatf("u%0d_one_pop", g), n_pops(g), 1);
        end
        repeat (10) @(posedge clk);
        #1;

        check("u0_reset_err", u[0].reset_err, 0);
        check("u0_idle_err", u[0].idle_err, 0);
        check("u0_bad_pop", u[0].bad_pop, 0);
        check("u0_unexpected", u[0].unexpected, 0);
        check("u0_queue_drained", u[0].rd_ptr, u[0].exp_q.size());
        check("u1_reset_err", u[1].reset_err, 0);
        check("u1_idle_err", u[1].idle_err, 0);
        check("u1_bad_pop", u[1].bad_pop, 0);
        check("u1_unexpected", u[1].unexpected, 0);
        check("u1_queue_drained", u[1].rd_ptr, u[1].exp_q.size());
        check("u2_reset_err", u[2].reset_err, 0);
        check("u2_idle_err", u[2].idle_err, 0);
        check("u2_bad_pop", u[2].bad_pop, 0);
        check("u2_unexpected", u[2].unexpected, 0);
        check("u2_queue_drained", u[2].rd_ptr, u[2].exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
